// File: rtl/jtframe_joyserial.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_joyserial
//  Description : Reader for daisy-chained parallel-in/serial-out joystick
//                adaptors (74HC165 style, active-low buttons). Produces a
//                shift clock from clk with an enable-style divider, loads
//                the chain, shifts PLAYERS*BITS bits in, idles for GAP shift
//                periods, then publishes all players at once.
//
//  Parameters  : PLAYERS  chained joysticks (1..4)
//                BITS     buttons per player (1..16); serial order per player
//                         is right, left, down, up, fire1, fire2, extras
//                DIV      clk cycles per joy_clk half-period (>= 4)
//                GAP      idle joy_clk periods between last bit and next load
//
//  Ports       : clk         system clock
//                rst         synchronous, active-high reset
//                joy_clk     shift clock to the adaptor
//                joy_load    active-low parallel load to the adaptor
//                joy_data    serial data from the adaptor (active-low, async)
//                joystick    player p in [16p+15:16p], active-high,
//                            bits BITS..15 of each word always 0
//                frame_done  one-clk pulse when joystick updates
//
//  Options     : JTFRAME_JOYSERIAL_DEBOUNCE_EN
//                  defined   -> an output bit changes only when two
//                               consecutive frames agree on its new value
//                  undefined -> joystick mirrors the latest frame
//
//  Revision    : 1.0  initial release
// ============================================================================
module jtframe_joyserial #(
    parameter int PLAYERS = 2,
    parameter int BITS    = 6,
    parameter int DIV     = 32,
    parameter int GAP     = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    joy_clk,
    output logic                    joy_load,
    input  logic                    joy_data,
    output logic [16*PLAYERS-1:0]   joystick,
    output logic                    frame_done
);

    localparam int c_N      = PLAYERS * BITS;
    localparam int c_DIV_W  = $clog2(DIV);
    localparam int c_BIT_W  = ($clog2(c_N) < 1) ? 1 : $clog2(c_N);
    localparam int c_GAP_W  = ($clog2(GAP + 1) < 1) ? 1 : $clog2(GAP + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_N - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                   r_state;
    logic [c_DIV_W-1:0]       r_div;
    logic [c_BIT_W-1:0]       r_bit;
    logic [c_GAP_W-1:0]       r_gap;
    logic [1:0]               r_sync;
    logic [c_N-1:0]           r_capture;
    logic                     r_joy_clk;
    logic                     r_joy_load;
    logic                     r_frame_done;
    logic [16*PLAYERS-1:0]    r_joystick;

    logic                     w_tick;
    logic                     w_rise;
    logic                     w_fall;
    logic [16*PLAYERS-1:0]    w_frame;

    assign w_tick = (r_div == c_DIV_LAST);
    assign w_rise = w_tick & ~r_joy_clk;
    assign w_fall = w_tick &  r_joy_clk;

    // Capture bit k belongs to player k/BITS, button k%BITS; the unused
    // upper buttons of every 16-bit word are zero-filled.
    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        assign w_frame[16*p +: 16] = 16'(r_capture[p*BITS +: BITS]);
    end

`ifdef JTFRAME_JOYSERIAL_DEBOUNCE_EN
    logic [16*PLAYERS-1:0]    r_prev_frame;
    logic [16*PLAYERS-1:0]    w_agree;
    logic [16*PLAYERS-1:0]    w_next_joy;

    // A bit takes the new frame's value only when the previous frame
    // carried the same value; otherwise the published value holds.
    assign w_agree    = ~(w_frame ^ r_prev_frame);
    assign w_next_joy = (w_agree & w_frame) | (~w_agree & r_joystick);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_frame <= '0;
        end else if (r_state == ST_GAP && w_rise && r_gap == c_GAP_LAST) begin
            r_prev_frame <= w_frame;
        end
    end
`else
    logic [16*PLAYERS-1:0]    w_next_joy;

    assign w_next_joy = w_frame;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_div        <= '0;
            r_bit        <= '0;
            r_gap        <= '0;
            r_sync       <= '0;
            r_capture    <= '0;
            r_joy_clk    <= 1'b0;
            r_joy_load   <= 1'b1;
            r_frame_done <= 1'b0;
            r_joystick   <= '0;
        end else begin
            r_sync       <= {r_sync[0], joy_data};
            r_frame_done <= 1'b0;
            r_div        <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_joy_clk <= ~r_joy_clk;
            end

            case (r_state)
                // joy_load is high on entry: the first rise drops it, the
                // second rise releases it, giving exactly one low period.
                ST_LOAD: begin
                    if (w_rise) begin
                        if (r_joy_load) begin
                            r_joy_load <= 1'b0;
                        end else begin
                            r_joy_load <= 1'b1;
                            r_bit      <= '0;
                            r_state    <= ST_SHIFT;
                        end
                    end
                end

                // The adaptor moves to the next bit on each rise; sampling
                // on the fall lands mid-bit, well after synchroniser delay.
                ST_SHIFT: begin
                    if (w_fall) begin
                        r_capture[r_bit] <= ~r_sync[1];
                        if (r_bit == c_BIT_LAST) begin
                            r_gap   <= '0;
                            r_state <= ST_GAP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end

                // The first rise after the last fall closes that bit's
                // clock period; the GAP idle periods are counted after it.
                ST_GAP: begin
                    if (w_rise) begin
                        if (r_gap == c_GAP_LAST) begin
                            r_joystick   <= w_next_joy;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_LOAD;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign joy_clk    = r_joy_clk;
    assign joy_load   = r_joy_load;
    assign joystick   = r_joystick;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_joyserial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtframe_joyserial
//  Description : Self-checking bench for jtframe_joyserial. Two instances:
//                the default configuration and PLAYERS=3/BITS=10/DIV=4/
//                GAP=2. Each drives a behavioural 74HC165 chain model and a
//                frame scoreboard; button patterns are randomised.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jtframe_joyserial;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        rst_v [2];
    logic [47:0] pat   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int P     = (g == 0) ? 2  : 3;
        localparam int B     = (g == 0) ? 6  : 10;
        localparam int D     = (g == 0) ? 32 : 4;
        localparam int G     = (g == 0) ? 12 : 2;
        localparam int N     = P * B;
        localparam int FRAME = (2 + N + G) * 2 * D;

        logic             jclk;
        logic             jload;
        logic             jdata = 1'b1;
        logic             fdone;
        logic [16*P-1:0]  joy;

        jtframe_joyserial #(
            .PLAYERS (P),
            .BITS    (B),
            .DIV     (D),
            .GAP     (G)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_v[g]),
            .joy_clk    (jclk),
            .joy_load   (jload),
            .joy_data   (jdata),
            .joystick   (joy),
            .frame_done (fdone)
        );

        // Pressed-button vector (serial order) to the published word.
        function automatic logic [63:0] expect_word(input logic [47:0] pr);
            logic [63:0] w;
            w = '0;
            for (int k = 0; k < N; k++) w[16*(k/B) + (k%B)] = pr[k];
            return w;
        endfunction

        logic [47:0] shreg    = '0;
        int          idx      = 0;
        logic        pjclk    = 1'b0;
        logic        pjload   = 1'b1;
        logic [63:0] q[$];
        logic [63:0] cur      = '0;
        logic [63:0] prevcap  = '0;
        int          glitches = 0;
        int          frames   = 0;
        int          last_done = 0;
        int          rel_cyc  = 0;
        int          lfall    = 0;

        always @(negedge clk) begin
            if (rst_v[g]) begin
                q.delete();
                cur      = '0;
                prevcap  = '0;
                idx      = 0;
                frames   = 0;
                glitches = 0;
                rel_cyc  = cyc;
                pjload   = 1'b1;
                pjclk    = 1'b0;
            end else begin
                // Adaptor: parallel load while low, shift on rising clock.
                if (!jload) begin
                    shreg = pat[g];
                    idx   = 0;
                    if (pjload) lfall = cyc;
                end else if (!pjload) begin
                    q.push_back(expect_word(shreg));
                    check($sformatf("load_low_len%0d", g), 64'(cyc - lfall), 64'(2*D));
                end else if (jclk && !pjclk) begin
                    idx++;
                end

                if (fdone) begin
                    logic [63:0] cap;
                    check($sformatf("frame_pending%0d", g), 64'(q.size() > 0), 64'd1);
                    cap = (q.size() > 0) ? q.pop_front() : '0;
`ifdef JTFRAME_JOYSERIAL_DEBOUNCE_EN
                    for (int i = 0; i < 64; i++)
                        if (cap[i] == prevcap[i]) cur[i] = cap[i];
`else
                    cur = cap;
`endif
                    prevcap = cap;
                    check($sformatf("joystick%0d", g), 64'(joy), cur);
                    check($sformatf("no_partial%0d", g), 64'(glitches), 64'd0);
                    glitches = 0;
                    if (frames == 0) begin
                        int dt;
                        dt = cyc - rel_cyc;
                        check($sformatf("first_done_window%0d", g),
                              64'(dt >= FRAME - 2*D && dt <= FRAME + 2*D), 64'd1);
                    end else begin
                        check($sformatf("frame_period%0d", g), 64'(cyc - last_done), 64'(FRAME));
                    end
                    last_done = cyc;
                    frames++;
                end else if (64'(joy) !== cur) begin
                    glitches++;
                end
                pjclk  = jclk;
                pjload = jload;
            end
            jdata = (idx < N) ? ~shreg[idx] : 1'b1;
        end
    end

    function automatic logic get_fdone(input int g);
        return (g == 0) ? g_inst[0].fdone : g_inst[1].fdone;
    endfunction

    function automatic logic get_jload(input int g);
        return (g == 0) ? g_inst[0].jload : g_inst[1].jload;
    endfunction

    task automatic wait_done(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (get_fdone(g) !== 1'b1 && t < 5000);
            if (get_fdone(g) !== 1'b1) begin
                check($sformatf("done_timeout%0d", g), 64'd0, 64'd1);
                return;
            end
        end
    endtask

    task automatic wait_load_rise(input int g);
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (get_jload(g) !== 1'b0 && t < 5000);
        do begin @(negedge clk); t++; end while (get_jload(g) !== 1'b1 && t < 10000);
        if (get_jload(g) !== 1'b1) check($sformatf("load_timeout%0d", g), 64'd0, 64'd1);
    endtask

    initial begin
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        pat[0]   = '0;
        pat[1]   = '0;
        repeat (4) @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        @(negedge clk);
        check("reset_joy0",   64'(g_inst[0].joy),   64'd0);
        check("reset_load0",  64'(g_inst[0].jload), 64'd1);
        check("reset_clk0",   64'(g_inst[0].jclk),  64'd0);
        check("reset_done0",  64'(g_inst[0].fdone), 64'd0);
        check("reset_joy1",   64'(g_inst[1].joy),   64'd0);
        check("reset_load1",  64'(g_inst[1].jload), 64'd1);

        fork
            begin
                wait_done(0, 2);
                check("idle_zero", 64'(g_inst[0].joy), 64'd0);

                @(posedge clk); #1;
                pat[0] = 48'h000_801;   // p0 right (k=0), p1 fire2 (k=11)
                wait_done(0, 3);
                check("p0right_p1fire2", 64'(g_inst[0].joy), 64'h0000_0000_0020_0001);

                repeat (6) begin
                    wait_load_rise(0);
                    repeat ($urandom_range(1, 2*12*32 - 1)) @(posedge clk);
                    #1;
                    pat[0] = 48'($urandom) & 48'hFFF;
                end
                wait_done(0, 3);

                wait_load_rise(0);
                repeat (10*32) @(posedge clk);
                #1 rst_v[0] = 1'b1;
                @(posedge clk);
                #1 rst_v[0] = 1'b0;
                @(negedge clk);
                check("midreset_joy",  64'(g_inst[0].joy),   64'd0);
                check("midreset_load", 64'(g_inst[0].jload), 64'd1);
                check("midreset_clk",  64'(g_inst[0].jclk),  64'd0);
                wait_done(0, 2);
            end
            begin
                @(posedge clk); #1;
                pat[1] = 48'd1 << 29;   // player 2, button 9
                wait_done(1, 3);
                check("p2b9_bit41", 64'(g_inst[1].joy), 64'h0000_0200_0000_0000);
                repeat (40) begin
                    repeat ($urandom_range(20, 600)) @(posedge clk);
                    #1;
                    pat[1] = {$urandom, $urandom} & 48'h0000_3FFF_FFFF;
                end
                wait_done(1, 3);
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
